// File: rtl/sprdma_ctrl.sv
// rtl/sprdma_ctrl.sv - sprite DMA: copies one RAM page to the OAM data port, one byte per three cycles
module sprdma_ctrl #(
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
   parameter int          BYTE_COUNT    = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  page,
   output logic [15:0] mem_addr,
   output logic        mem_wr,
   output logic [7:0]  mem_dout,
   input  logic [7:0]  mem_din,
   input  logic        mem_invalid,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, DONE} state_t;

   localparam logic [7:0] LAST_IDX = 8'(BYTE_COUNT - 1);

   state_t      state_q, state_d;
   logic [7:0]  page_q;
   logic [7:0]  idx_q;
   logic [7:0]  data_q;
   logic        err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         page_q  <= 8'h00;
         idx_q   <= 8'h00;
         data_q  <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  page_q <= page;
                  idx_q  <= 8'h00;
                  err_q  <= 1'b0;
               end
            end
            RD_DATA: begin
               data_q <= mem_din;
               if (mem_invalid) err_q <= 1'b1;
            end
            WR: begin
               if (mem_invalid) err_q <= 1'b1;
               // idx stops at the last byte so a full page never touches page+1
               if (idx_q != LAST_IDX) idx_q <= idx_q + 8'h01;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RD_ADDR;
         RD_ADDR: state_d = RD_DATA;
         RD_DATA: state_d = WR;
         WR:      state_d = (idx_q == LAST_IDX) ? DONE : RD_ADDR;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode only registered state, so bus inputs never reach them combinationally
   always_comb begin
      mem_addr = 16'h0000;
      mem_wr   = 1'b0;
      mem_dout = 8'h00;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         RD_ADDR, RD_DATA: begin
            mem_addr = {page_q, idx_q};
            busy     = 1'b1;
         end
         WR: begin
            mem_addr = OAM_DATA_ADDR;
            mem_wr   = 1'b1;
            mem_dout = data_q;
            busy     = 1'b1;
         end
         DONE: done = 1'b1;
         default: ;
      endcase
   end

   assign err = err_q;

endmodule
